// File: rtl/alpharetz_operand_fetch_if.sv
// Operand-fetch stage bus bundle.
// Groups the decode offer/accept handshake, both register-file read ports,
// the writeback snoop, the execute-slot handshake and the stage enables/flush.
//   master : the operand-fetch stage (drives dec_ready, rf_rd_*, ex_*)
//   slave  : the surrounding pipeline (decode, register file, writeback, execute)
interface alpharetz_operand_fetch_if #(
  parameter int CPU_DATA_WIDTH = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CTRL_WIDTH     = 16
);
  logic                      clk_en;
  logic                      sys_en;
  logic                      flush;
  // decode -> fetch
  logic                      dec_valid;
  logic                      dec_ready;
  logic [REG_ADDR_WIDTH-1:0] dec_rs1;
  logic [REG_ADDR_WIDTH-1:0] dec_rs2;
  logic                      dec_rs1_used;
  logic                      dec_rs2_used;
  logic [REG_ADDR_WIDTH-1:0] dec_rd;
  logic                      dec_rd_wr;
  logic [CTRL_WIDTH-1:0]     dec_ctrl;
  // register file read ports
  logic                      rf_rd_en_a;
  logic                      rf_rd_en_b;
  logic [REG_ADDR_WIDTH-1:0] rf_rd_addr_a;
  logic [REG_ADDR_WIDTH-1:0] rf_rd_addr_b;
  logic [CPU_DATA_WIDTH-1:0] rf_rd_data_a;
  logic [CPU_DATA_WIDTH-1:0] rf_rd_data_b;
  // writeback snoop
  logic                      wb_valid;
  logic [REG_ADDR_WIDTH-1:0] wb_addr;
  logic [CPU_DATA_WIDTH-1:0] wb_data;
  // fetch -> execute slot
  logic                      ex_valid;
  logic                      ex_ready;
  logic [CPU_DATA_WIDTH-1:0] ex_op_a;
  logic [CPU_DATA_WIDTH-1:0] ex_op_b;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic                      ex_rd_wr;
  logic [CTRL_WIDTH-1:0]     ex_ctrl;

  modport master (
    input  clk_en, sys_en, flush,
    input  dec_valid, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used,
    input  dec_rd, dec_rd_wr, dec_ctrl,
    output dec_ready,
    output rf_rd_en_a, rf_rd_en_b, rf_rd_addr_a, rf_rd_addr_b,
    input  rf_rd_data_a, rf_rd_data_b,
    input  wb_valid, wb_addr, wb_data,
    output ex_valid, ex_op_a, ex_op_b, ex_rd, ex_rd_wr, ex_ctrl,
    input  ex_ready
  );

  modport slave (
    output clk_en, sys_en, flush,
    output dec_valid, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used,
    output dec_rd, dec_rd_wr, dec_ctrl,
    input  dec_ready,
    input  rf_rd_en_a, rf_rd_en_b, rf_rd_addr_a, rf_rd_addr_b,
    output rf_rd_data_a, rf_rd_data_b,
    output wb_valid, wb_addr, wb_data,
    input  ex_valid, ex_op_a, ex_op_b, ex_rd, ex_rd_wr, ex_ctrl,
    output ex_ready
  );
endinterface

// File: rtl/alpharetz_operand_fetch.sv
// Operand-fetch / issue stage between decode and execute.
// Reads both register-file ports, bypasses same-cycle writeback data, tracks
// outstanding destination writes in a per-register scoreboard, stalls decode
// on RAW/WAW hazards and registers the issued instruction into a valid/ready
// slot toward execute.
// Ports:
//   clk      : clock
//   sync_rst : synchronous active-high reset, overrides everything
//   bus      : alpharetz_operand_fetch_if.master (enables, flush, decode,
//              register file, writeback and execute-slot signals)
module alpharetz_operand_fetch #(
  parameter int CPU_DATA_WIDTH = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CPU_REG_COUNT  = 2**REG_ADDR_WIDTH,
  parameter int CTRL_WIDTH     = 16
) (
  input  logic clk,
  input  logic sync_rst,
  alpharetz_operand_fetch_if.master bus
);

  logic                      adv;
  logic [CPU_REG_COUNT-1:0]  sb;
  logic [CPU_REG_COUNT-1:0]  sb_next;
  logic [CPU_REG_COUNT-1:0]  wb_hit;
  logic [CPU_REG_COUNT-1:0]  busy;
  logic                      hazard;
  logic                      slot_free;
  logic                      dec_ready;
  logic                      xfer;
  logic [CPU_DATA_WIDTH-1:0] src_a;
  logic [CPU_DATA_WIDTH-1:0] src_b;

  logic                      ex_valid_q;
  logic [CPU_DATA_WIDTH-1:0] ex_op_a_q;
  logic [CPU_DATA_WIDTH-1:0] ex_op_b_q;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_q;
  logic                      ex_rd_wr_q;
  logic [CTRL_WIDTH-1:0]     ex_ctrl_q;

  // x0 reads as zero; a same-cycle writeback to the source beats the
  // (still stale) register file output.
  function automatic logic [CPU_DATA_WIDTH-1:0] src_value(
    input logic                      used,
    input logic [REG_ADDR_WIDTH-1:0] addr,
    input logic [CPU_DATA_WIDTH-1:0] rf_data,
    input logic                      wb_v,
    input logic [REG_ADDR_WIDTH-1:0] wb_a,
    input logic [CPU_DATA_WIDTH-1:0] wb_d
  );
    if (!used || addr == '0) return '0;
    if (wb_v && wb_a == addr) return wb_d;
    return rf_data;
  endfunction

  assign adv = bus.clk_en & bus.sys_en;

  assign bus.rf_rd_addr_a = bus.dec_rs1;
  assign bus.rf_rd_addr_b = bus.dec_rs2;
  assign bus.rf_rd_en_a   = bus.dec_valid & bus.dec_rs1_used;
  assign bus.rf_rd_en_b   = bus.dec_valid & bus.dec_rs2_used;

  assign src_a = src_value(bus.dec_rs1_used, bus.dec_rs1, bus.rf_rd_data_a,
                           bus.wb_valid, bus.wb_addr, bus.wb_data);
  assign src_b = src_value(bus.dec_rs2_used, bus.dec_rs2, bus.rf_rd_data_b,
                           bus.wb_valid, bus.wb_addr, bus.wb_data);

  always_comb begin
    wb_hit = '0;
    if (bus.wb_valid) wb_hit[bus.wb_addr] = 1'b1;
  end

  // sb[0] is held at zero, so register 0 can never appear busy.
  assign busy = sb & ~wb_hit;

  assign hazard = (bus.dec_rs1_used & busy[bus.dec_rs1])
                | (bus.dec_rs2_used & busy[bus.dec_rs2])
                | (bus.dec_rd_wr & busy[bus.dec_rd]);

  assign slot_free = ~ex_valid_q | bus.ex_ready;
  assign dec_ready = adv & ~sync_rst & ~bus.flush & ~hazard & slot_free;
  assign xfer      = bus.dec_valid & dec_ready;

  // Clears are applied before the issue set so that a writeback and a new
  // writer of the same register in one cycle leave the register pending.
  always_comb begin
    sb_next = sb;
    if (bus.flush && ex_valid_q && ex_rd_wr_q) sb_next[ex_rd_q] = 1'b0;
    if (bus.wb_valid) sb_next[bus.wb_addr] = 1'b0;
    if (xfer && bus.dec_rd_wr) sb_next[bus.dec_rd] = 1'b1;
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      sb         <= '0;
      ex_valid_q <= 1'b0;
      ex_op_a_q  <= '0;
      ex_op_b_q  <= '0;
      ex_rd_q    <= '0;
      ex_rd_wr_q <= 1'b0;
      ex_ctrl_q  <= '0;
    end else if (adv) begin
      sb <= sb_next;
      if (xfer) begin
        ex_valid_q <= 1'b1;
        ex_op_a_q  <= src_a;
        ex_op_b_q  <= src_b;
        ex_rd_q    <= bus.dec_rd;
        ex_rd_wr_q <= bus.dec_rd_wr;
        ex_ctrl_q  <= bus.dec_ctrl;
      end else if (bus.flush || bus.ex_ready) begin
        ex_valid_q <= 1'b0;
      end
    end
  end

  assign bus.dec_ready = dec_ready;
  assign bus.ex_valid  = ex_valid_q;
  assign bus.ex_op_a   = ex_op_a_q;
  assign bus.ex_op_b   = ex_op_b_q;
  assign bus.ex_rd     = ex_rd_q;
  assign bus.ex_rd_wr  = ex_rd_wr_q;
  assign bus.ex_ctrl   = ex_ctrl_q;

endmodule

// File: doc/alpharetz_operand_fetch.md
Name: alpharetz_operand_fetch

Overview:
- Operand-fetch / issue stage sitting between decode and execute.
- Drives both read ports of the CPU register file and tracks outstanding destination writes with a per-register scoreboard.
- Bypasses same-cycle writeback data and stalls decode on RAW/WAW hazards.
- Registers the issued instruction and its operands into a valid/ready slot toward execute.

Parameters:
- CPU_DATA_WIDTH, 32, operand/data width
- REG_ADDR_WIDTH, 5, register address width
- CPU_REG_COUNT, 32, number of architectural registers (2**REG_ADDR_WIDTH)
- CTRL_WIDTH, 16, opaque decoded control payload passed to execute

Ports:
- clk  in  1  clock
- sync_rst  in  1  synchronous active-high reset
- clk_en  in  1  clock enable; state frozen when 0
- sys_en  in  1  system enable; state frozen when 0
- flush  in  1  discard held execute-slot instruction
- dec_valid  in  1  decode offers instruction
- dec_ready  out  1  instruction accepted this cycle
- dec_rs1, dec_rs2  in  REG_ADDR_WIDTH  source register addresses
- dec_rs1_used, dec_rs2_used  in  1  source actually read
- dec_rd  in  REG_ADDR_WIDTH  destination register
- dec_rd_wr  in  1  instruction writes dec_rd
- dec_ctrl  in  CTRL_WIDTH  control payload
- rf_rd_en_a, rf_rd_en_b  out  1  register file read enables
- rf_rd_addr_a, rf_rd_addr_b  out  REG_ADDR_WIDTH  register file read addresses
- rf_rd_data_a, rf_rd_data_b  in  CPU_DATA_WIDTH  combinational read data (zero when enable low)
- wb_valid  in  1  writeback occurring this cycle (same strobe as register file write)
- wb_addr  in  REG_ADDR_WIDTH  writeback register
- wb_data  in  CPU_DATA_WIDTH  writeback data
- ex_valid  out  1  execute slot holds instruction
- ex_ready  in  1  execute consumes slot
- ex_op_a, ex_op_b  out  CPU_DATA_WIDTH  operands
- ex_rd  out  REG_ADDR_WIDTH  destination
- ex_rd_wr  out  1  destination write flag
- ex_ctrl  out  CTRL_WIDTH  control payload

Behaviour:
- Clocking and reset: one clock, clk. sync_rst is synchronous, active-high and overrides everything.
- Reset values: ex_valid, ex_op_a, ex_op_b, ex_rd, ex_rd_wr and ex_ctrl are all 0; the scoreboard is all 0.
- Enable gating: adv = clk_en & sys_en. All state updates require adv; when adv=0 all registers hold and dec_ready=0.
- Read ports:
  - rf_rd_addr_a = dec_rs1; rf_rd_en_a = dec_valid & dec_rs1_used.
  - Port b likewise with dec_rs2 / dec_rs2_used.
- Source value, per source s:
  - If not used: 0.
  - Else if s==0: 0.
  - Else if wb_valid & wb_addr==s: wb_data (bypass).
  - Else: rf data.
- Busy definition: busy(r) = sb[r] & ~(wb_valid & wb_addr==r). Register 0 is never busy.
- Hazard, any of:
  - rs1 used and busy;
  - rs2 used and busy;
  - dec_rd_wr & dec_rd!=0 & busy(dec_rd) (WAW).
- slot_free = ~ex_valid | ex_ready.
- dec_ready = adv & ~sync_rst & ~flush & ~hazard & slot_free. This is combinational and does not depend on dec_valid.
- Transfer: dec_valid & dec_ready. On transfer, the slot loads the source values, dec_rd, dec_rd_wr and dec_ctrl, and ex_valid=1. Latency is 1 cycle from decode handshake to ex_valid.
- Slot release without refill: ex_valid & ex_ready & adv & no transfer sets ex_valid=0. Data fields hold their last values.
- Flush (with adv):
  - ex_valid->0 and no transfer occurs that cycle.
  - If the dropped slot had ex_rd_wr & ex_rd!=0, clear sb[ex_rd].
  - Flush does not cancel writebacks already in flight.
- Scoreboard, per cycle with adv:
  - clear sb[wb_addr] when wb_valid;
  - set sb[dec_rd] on transfer with dec_rd_wr & dec_rd!=0;
  - set wins over clear on the same index in the same cycle.
- sb[0] is constant 0. Writebacks to untracked registers are harmless.
- Handshake stability: ex_* outputs are stable while ex_valid & ~ex_ready.

Test Plan:
- Reset and basic issue: assert sync_rst 2 cycles, then release. ex_valid=0 and dec_ready=1. Issue rs1=3 (rf=0x11), rs2=4 (rf=0x22), rd=5 -> next cycle ex_valid=1, ex_op_a=0x11, ex_op_b=0x22, sb[5]=1.
- RAW stall then bypass: issue rd=5 with ex_ready=1, then offer rs1=5 -> dec_ready=0. Drive wb_valid, wb_addr=5, wb_data=0xDEAD -> dec_ready=1 that cycle, ex_op_a=0xDEAD, sb[5]=0.
- x0 rules: rs1=0 with rf returning 0xFFFF and wb_addr=0, wb_data=0x1234 -> ex_op_a=0. Issuing rd=0 leaves sb all 0.
- Backpressure: ex_ready=0 with slot full -> dec_ready=0 and ex_* held 3 cycles. ex_ready=1 with dec_valid -> back-to-back issue, no bubble.
- Simultaneous set/clear and WAW: wb to r7 and issue with rd=7 in the same cycle -> sb[7]=1. A following instruction with rd=7 stalls until the next wb to 7.
- Flush and enables: slot holds rd=9, flush=1 -> ex_valid=0, sb[9]=0. With clk_en=0 or sys_en=0 -> dec_ready=0 and no state change.
